// File: rtl/data_memory_bridge_pkg.sv
// Shared definitions for the data memory bridge: access size encodings,
// handshake FSM states and byte-enable constants.
`timescale 1ns/1ps
package data_memory_bridge_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [3:0] BE_ALL  = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    // True when the low address bits do not suit the access size.
    // Size 2'b11 is handled like a word.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] offset);
        logic bad;
        case (sz)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            default:   bad = (offset != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_memory_bridge_load_store_aligner.sv
// Purely combinational lane steering for the data memory bridge.
// Store side: byte enables and lane-replicated write data from the live
// address offset, size and store data. Load side: picks the addressed lane
// out of the captured memory word and sign- or zero-extends it.
// BIG_ENDIAN=1 maps offset 0 to bits 31:24; BIG_ENDIAN=0 mirrors the lanes.
`timescale 1ns/1ps
module data_memory_bridge_load_store_aligner
    import data_memory_bridge_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [1:0]  st_offset,
    input  logic [1:0]  st_size,
    input  logic [31:0] writedata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [31:0] ld_word,
    input  logic [1:0]  ld_offset,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    output logic [31:0] rdata
);

    // Physical byte lane (0 = bits 7:0) addressed by a byte offset.
    function automatic logic [1:0] byte_lane(input logic [1:0] offset);
        return BIG_ENDIAN ? (2'd3 - offset) : offset;
    endfunction

    // Whether a halfword at this address occupies bits 31:16.
    function automatic logic half_upper(input logic a1);
        return BIG_ENDIAN ? ~a1 : a1;
    endfunction

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store formatting: enables follow the addressed lanes, data is replicated
    // so the memory can take it from whichever lane is enabled.
    always_comb begin
        be    = BE_NONE;
        wdata = writedata;
        case (st_size)
            SIZE_BYTE: begin
                be    = 4'b0001 << byte_lane(st_offset);
                wdata = {4{writedata[7:0]}};
            end
            SIZE_HALF: begin
                be    = half_upper(st_offset[1]) ? 4'b1100 : 4'b0011;
                wdata = {2{writedata[15:0]}};
            end
            default: begin
                be    = BE_ALL;
                wdata = writedata;
            end
        endcase
    end

    // Load formatting: extract the addressed lane and extend it to 32 bits.
    always_comb begin
        ld_byte = ld_word[{byte_lane(ld_offset), 3'b000} +: 8];
        ld_half = half_upper(ld_offset[1]) ? ld_word[31:16] : ld_word[15:0];
        case (ld_size)
            SIZE_BYTE: rdata = ld_unsigned ? {24'h000000, ld_byte}
                                           : {{24{ld_byte[7]}}, ld_byte};
            SIZE_HALF: rdata = ld_unsigned ? {16'h0000, ld_half}
                                           : {{16{ld_half[15]}}, ld_half};
            default:   rdata = ld_word;
        endcase
    end

endmodule

// File: rtl/data_memory_bridge.sv
// Data memory bridge: turns the single-cycle core's load/store into a
// req/ack handshake with an external word-wide memory, stalling the core
// until the access completes (IDLE -> WAIT -> DONE).
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses skip the
// memory and pulse misalign for one cycle in a FAULT state.
`timescale 1ns/1ps
module data_memory_bridge
    import data_memory_bridge_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memread,
    input  logic                  memwrite,
    input  logic [1:0]            size,
    input  logic                  loadunsigned,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  stall,
    output logic                  misalign,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);

    state_t                state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [1:0]            offset_q, offset_d;
    logic [1:0]            size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic [31:0]           word_q, word_d;

    logic                  access;
    logic                  trap_hit;
    logic [3:0]            fmt_be;
    logic [31:0]           fmt_wdata;
    logic [31:0]           fmt_rdata;

    assign access = memread | memwrite;

`ifdef MISALIGN_TRAP_EN
    assign trap_hit = is_misaligned(size, addr[1:0]);
`else
    assign trap_hit = 1'b0;
`endif

    data_memory_bridge_load_store_aligner #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) load_store_aligner (
        .st_offset   (addr[1:0]),
        .st_size     (size),
        .writedata   (writedata),
        .be          (fmt_be),
        .wdata       (fmt_wdata),
        .ld_word     (word_q),
        .ld_offset   (offset_q),
        .ld_size     (size_q),
        .ld_unsigned (unsigned_q),
        .rdata       (fmt_rdata)
    );

    // Handshake FSM next state; the request is latched on leaving IDLE so the
    // memory sees stable signals however long it takes to ack.
    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        offset_d    = offset_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        word_d      = word_q;
        case (state_q)
            IDLE: begin
                if (access && trap_hit) begin
                    state_d = FAULT;
                end else if (access) begin
                    state_d     = WAIT;
                    mem_we_d    = memwrite;
                    mem_addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_be_d    = fmt_be;
                    mem_wdata_d = fmt_wdata;
                    offset_d    = addr[1:0];
                    size_d      = size;
                    unsigned_d  = loadunsigned;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    state_d = DONE;
                    word_d  = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
        mem_req_d = (state_d == WAIT);
    end

    // State and latched request registers; reset drops mem_req at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= BE_NONE;
            mem_wdata_q <= '0;
            offset_q    <= 2'b00;
            size_q      <= SIZE_BYTE;
            unsigned_q  <= 1'b0;
            word_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            offset_q    <= offset_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            word_q      <= word_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    assign misalign_d = (state_d == FAULT);

    // One-cycle fault pulse, registered alongside the FAULT state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    // Core-facing status: stall is raised in IDLE as soon as a memory op
    // appears, and load data is only presented in the retiring DONE cycle.
    always_comb begin
        stall    = 1'b0;
        readdata = '0;
        case (state_q)
            IDLE:    stall = access;
            WAIT:    stall = 1'b1;
            DONE:    readdata = fmt_rdata;
            default: stall = 1'b0;
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/data_memory_bridge.md
Name: data_memory_bridge

Overview:
- Sits directly downstream of the single-cycle datapath, between its memory-stage outputs (aluout as address, writedata) and its readdata input on one side, and an external word-wide memory using a req/ack handshake on the other.
- Turns the core's single-cycle load/store into a multi-cycle handshake, asserting stall until the access completes.
- Generates big-endian byte enables, write-lane replication, and sign/zero-extended load data for byte, halfword and word accesses.

Parameters:
- BIG_ENDIAN, 1, byte-lane order; 1 = MIPS big-endian (offset 0 -> bits 31:24), 0 = little-endian.
- ADDR_WIDTH, 32, width of addr and mem_addr.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- memread  in  1  current instruction is a load
- memwrite  in  1  current instruction is a store
- size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- loadunsigned  in  1  1 = zero-extend sub-word loads, 0 = sign-extend
- addr  in  ADDR_WIDTH  byte address (datapath aluout)
- writedata  in  32  store data, right-justified
- readdata  out  32  formatted load result to datapath
- stall  out  1  core must hold PC and suppress register/memory writeback
- misalign  out  1  alignment fault pulse (see Optional Feature)
- mem_req  out  1  request valid
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_WIDTH  word-aligned address {addr[ADDR_WIDTH-1:2],2'b00}
- mem_be  out  4  byte enables, bit 3 = bits 31:24
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completion; rdata valid in same cycle for reads
- mem_rdata  in  32  raw memory word

Behaviour:
- Reset (reset low, asynchronous): state IDLE. mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, readdata=0, misalign=0. Internal captured-data register = 0. stall=0.
- Reset mid-access drops mem_req immediately. Any in-flight ack is ignored after release.
- State IDLE:
  - stall = memread|memwrite, combinational in the same cycle.
  - If an access is requested: latch addr, size, loadunsigned, we (memwrite wins if both asserted), and formatted wdata/be into registers; next state WAIT.
- State WAIT:
  - mem_req=1. mem_we, mem_addr, mem_be and mem_wdata are driven from the latched registers and held stable; stall=1.
  - On mem_ack=1: capture mem_rdata, next state DONE. Otherwise remain in WAIT, with no timeout.
- State DONE:
  - mem_req=0, stall=0. readdata is the formatted captured word; the core retires the instruction on this edge.
  - Next state IDLE unconditionally; memread/memwrite in DONE never start a new access.
- Latency: zero-wait memory (ack in first WAIT cycle) gives 3 cycles per memory instruction (IDLE, WAIT, DONE). Each extra wait cycle adds one.
- Non-memory instructions: no stall, zero overhead.
- mem_ack outside WAIT is ignored.
- Byte enables (BIG_ENDIAN=1):
  - byte: offset 0->1000, 1->0100, 2->0010, 3->0001.
  - half: addr[1]=0->1100, 1->0011.
  - word: 1111.
  - BIG_ENDIAN=0 mirrors these patterns.
- Write data: byte = {4{wd[7:0]}}; half = {2{wd[15:0]}}; word = wd.
- Load data: the lane selected by the same mapping, extended to 32 bits per the latched loadunsigned. Word loads pass through unchanged. readdata is 0 in IDLE and WAIT.
- Misalignment without the feature: the offending low address bits are ignored (half uses addr[1] only, word ignores addr[1:0]).

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, never raises mem_req.
  - IDLE goes to state FAULT. In FAULT: stall=0, misalign=1 for exactly that cycle, readdata=0, no memory write. Next state IDLE.
- Undefined: FAULT state absent, misalign tied to 0, behaviour as above.

Decomposition:
- Shared package:
  - Size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD.
  - FSM state enum IDLE/WAIT/DONE/FAULT.
  - Byte-enable constants BE_ALL, BE_NONE.
- Natural sub-module: load_store_aligner. It is purely combinational: it computes mem_be and mem_wdata from (addr[1:0], size, writedata) and readdata from (captured word, latched offset, size, loadunsigned). It is instantiated once; the FSM and registers stay in data_memory_bridge.

Test Plan:
- Reset low during WAIT with mem_req=1 -> mem_req=0 immediately, all outputs 0, state IDLE; ack one cycle after release ignored, no DONE cycle.
- Load word addr 0x10010004, memory acks after 2 wait cycles with 0xDEADBEEF -> mem_addr 0x10010004, be 1111, stall high 4 cycles, readdata 0xDEADBEEF in DONE with stall 0.
- Load byte addr 0x10010001, rdata 0x12F45678, signed -> be 0100, readdata 0xFFFFFFF4; repeat with loadunsigned=1 -> 0x000000F4.
- Store half addr 0x10010002, writedata 0x0000ABCD -> mem_we=1, be 0011, mem_wdata 0xABCDABCD, held stable across 3 non-ack cycles.
- Back-to-back stores, zero-wait memory, then a non-memory instruction -> exactly one mem_req pulse per store, 3 cycles each, no stall on the ALU instruction.
- MISALIGN_TRAP_EN defined, load word addr 0x10010002 -> no mem_req, misalign=1 for one cycle, readdata 0; undefined -> access issued to 0x10010000, be 1111.
